// File: rtl/hdmi_packet_pkg.sv
// hdmi_packet_pkg: HB0 packet type codes, the packet type enum, the scheduler
// FSM state type and the layout of the pending-request vector.
// Build option: SPD_INFOFRAME_EN adds the SPD InfoFrame request to the
// pending vector; without it the vector carries ACR, AVI and AUDIO_IF only.
package hdmi_packet_pkg;

   localparam logic [7:0] HB0_NULL         = 8'h00;
   localparam logic [7:0] HB0_ACR          = 8'h01;
   localparam logic [7:0] HB0_AUDIO_SAMPLE = 8'h02;
   localparam logic [7:0] HB0_AVI          = 8'h82;
   localparam logic [7:0] HB0_SPD          = 8'h83;
   localparam logic [7:0] HB0_AUDIO_IF     = 8'h84;

   typedef enum logic [7:0] {
      PKT_NULL         = HB0_NULL,
      PKT_ACR          = HB0_ACR,
      PKT_AUDIO_SAMPLE = HB0_AUDIO_SAMPLE,
      PKT_AVI          = HB0_AVI,
      PKT_SPD          = HB0_SPD,
      PKT_AUDIO_IF     = HB0_AUDIO_IF
   } packet_type_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_HOLD  = 2'd2
   } sched_state_e;

   // Bit positions inside the pending-request vector.
   localparam int PEND_ACR = 0;
   localparam int PEND_AVI = 1;
   localparam int PEND_AIF = 2;
`ifdef SPD_INFOFRAME_EN
   localparam int PEND_SPD = 3;
   localparam int PEND_W   = 4;
`else
   localparam int PEND_W   = 3;
`endif

   // True for the InfoFrame types that take part in defer/promotion.
   function automatic logic is_infoframe(input logic [7:0] t);
      return (t == HB0_AVI) || (t == HB0_AUDIO_IF) || (t == HB0_SPD);
   endfunction

endpackage

// File: rtl/packet_priority_select.sv
// packet_priority_select: combinational arbiter choosing the HB0 type for the
// next data island slot from the pending requests.
// Order: ACR > promoted InfoFrame > AUDIO_SAMPLE > AVI > AUDIO_IF > SPD > NULL.
// Build option: SPD_INFOFRAME_EN enables the SPD candidate.
module packet_priority_select
   import hdmi_packet_pkg::*;
(
   input  logic [PEND_W-1:0] pending,
   input  logic              audio_sample_valid,
   input  logic              promote,
   output logic [7:0]        sel_type
);

   // Fixed-priority pick; a promoted InfoFrame jumps ahead of audio samples.
   // NOTE: sel_type gets a default before the if-chain so every path assigns
   // it and no latch is inferred.
   always_comb begin
      sel_type = PKT_NULL;
      if (pending[PEND_ACR])
         sel_type = PKT_ACR;
      else if (promote && pending[PEND_AVI])
         sel_type = PKT_AVI;
      else if (promote && pending[PEND_AIF])
         sel_type = PKT_AUDIO_IF;
`ifdef SPD_INFOFRAME_EN
      else if (promote && pending[PEND_SPD])
         sel_type = PKT_SPD;
`endif
      else if (audio_sample_valid)
         sel_type = PKT_AUDIO_SAMPLE;
      else if (pending[PEND_AVI])
         sel_type = PKT_AVI;
      else if (pending[PEND_AIF])
         sel_type = PKT_AUDIO_IF;
`ifdef SPD_INFOFRAME_EN
      else if (pending[PEND_SPD])
         sel_type = PKT_SPD;
`endif
   end

endmodule

// File: rtl/data_island_scheduler.sv
// data_island_scheduler: grants HDMI data island packet slots to ACR, audio
// sample and InfoFrame sources, holding each grant for PACKET_CYCLES pixel
// clocks. InfoFrames that keep losing to audio samples are promoted after
// INFOFRAME_MAX_DEFER losses.
// Build option: SPD_INFOFRAME_EN schedules the SPD InfoFrame (0x83).
module data_island_scheduler
   import hdmi_packet_pkg::*;
#(
   parameter int INFOFRAME_MAX_DEFER = 8,
   parameter int PACKET_CYCLES       = 32
) (
   input  logic       clk_pixel,
   input  logic       reset_n,
   input  logic       frame_start,
   input  logic       packet_slot,
   input  logic       clk_audio_counter_wrap,
   input  logic       audio_sample_valid,
   output logic       audio_sample_pop,
   output logic [7:0] packet_type,
   output logic       packet_start,
   output logic       packet_active,
   output logic       slot_overrun,
   input  logic       overrun_clear
);

   localparam int DEFER_W = $clog2(INFOFRAME_MAX_DEFER + 1);
   localparam int HOLD_W  = $clog2(PACKET_CYCLES);

   localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(INFOFRAME_MAX_DEFER);
   // HOLD lasts PACKET_CYCLES-1 cycles, counted 0 .. PACKET_CYCLES-2.
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(PACKET_CYCLES - 2);

   sched_state_e        state;
   sched_state_e        state_next;
   logic                wrap_q;
   logic                acr_edge;
   logic                acr_pending;
   logic                avi_pending;
   logic                aif_pending;
`ifdef SPD_INFOFRAME_EN
   logic                spd_pending;
`endif
   logic [PEND_W-1:0]   pending;
   logic                any_if_pending;
   logic [DEFER_W-1:0]  defer_cnt;
   logic                promote;
   logic [7:0]          sel_type;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                take_slot;
   logic                in_grant;

   assign acr_edge  = clk_audio_counter_wrap ^ wrap_q;
   assign take_slot = packet_slot && (state == ST_IDLE);
   assign in_grant  = (state == ST_GRANT);
   assign promote   = (defer_cnt == DEFER_MAX);

`ifdef SPD_INFOFRAME_EN
   assign pending        = {spd_pending, aif_pending, avi_pending, acr_pending};
   assign any_if_pending = avi_pending | aif_pending | spd_pending;
`else
   assign pending        = {aif_pending, avi_pending, acr_pending};
   assign any_if_pending = avi_pending | aif_pending;
`endif

   packet_priority_select u_select (
      .pending            (pending),
      .audio_sample_valid (audio_sample_valid),
      .promote            (promote),
      .sel_type           (sel_type)
   );

   // FSM state register.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Next state and per-state outputs; outputs follow the state register so
   // an asynchronous reset drops them at once.
   always_comb begin
      state_next       = state;
      packet_start     = 1'b0;
      packet_active    = 1'b0;
      audio_sample_pop = 1'b0;
      case (state)
         ST_IDLE: begin
            if (packet_slot) state_next = ST_GRANT;
         end
         ST_GRANT: begin
            packet_start     = 1'b1;
            packet_active    = 1'b1;
            audio_sample_pop = (packet_type == HB0_AUDIO_SAMPLE);
            state_next       = ST_HOLD;
         end
         ST_HOLD: begin
            packet_active = 1'b1;
            if (hold_cnt == HOLD_LAST) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Cycle counter for the HOLD phase; parked at zero outside HOLD.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n)              hold_cnt <= '0;
      else if (state == ST_HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
      else                       hold_cnt <= '0;
   end

   // Selected type captured when a slot is accepted, held until the next one.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n)       packet_type <= HB0_NULL;
      else if (take_slot) packet_type <= sel_type;
   end

   // Registered copy of the ACR toggle; any difference is one request.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) wrap_q <= 1'b0;
      else          wrap_q <= clk_audio_counter_wrap;
   end

   // Pending flags: the granted flag clears in GRANT, a same-cycle request
   // keeps it set.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         acr_pending <= 1'b0;
         avi_pending <= 1'b0;
         aif_pending <= 1'b0;
      end else begin
         acr_pending <= (acr_pending & ~(in_grant && (packet_type == HB0_ACR)))
                        | acr_edge;
         avi_pending <= (avi_pending & ~(in_grant && (packet_type == HB0_AVI)))
                        | frame_start;
         aif_pending <= (aif_pending & ~(in_grant && (packet_type == HB0_AUDIO_IF)))
                        | frame_start;
      end
   end

`ifdef SPD_INFOFRAME_EN
   // SPD request flag, same set/clear rule as the other InfoFrames.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) spd_pending <= 1'b0;
      else          spd_pending <= (spd_pending & ~(in_grant && (packet_type == HB0_SPD)))
                                   | frame_start;
   end
`endif

   // Counts audio wins over waiting InfoFrames; saturates at the promote
   // threshold and restarts whenever an InfoFrame is granted.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         defer_cnt <= '0;
      end else if (take_slot) begin
         if (is_infoframe(sel_type))
            defer_cnt <= '0;
         else if ((sel_type == HB0_AUDIO_SAMPLE) && any_if_pending && !promote)
            defer_cnt <= defer_cnt + DEFER_W'(1);
      end
   end

   // Sticky overrun flag; a new overrun beats a simultaneous clear.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n)                             slot_overrun <= 1'b0;
      else if (packet_slot && state != ST_IDLE) slot_overrun <= 1'b1;
      else if (overrun_clear)                   slot_overrun <= 1'b0;
   end

endmodule

// File: tb/tb_data_island_scheduler.sv
// tb_data_island_scheduler: directed bench for data_island_scheduler. A
// slot-level model (request flags, loss count, remaining packet cycles) is
// compared with the DUT on every falling edge; literal checks pin the model
// on the documented scenarios. Honors SPD_INFOFRAME_EN like the design.
module tb_data_island_scheduler;

   localparam int PC   = 32;
   localparam int MAXD = 8;

   logic       clk_pixel = 1'b0;
   logic       reset_n;
   logic       frame_start;
   logic       packet_slot;
   logic       clk_audio_counter_wrap;
   logic       audio_sample_valid;
   logic       audio_sample_pop;
   logic [7:0] packet_type;
   logic       packet_start;
   logic       packet_active;
   logic       slot_overrun;
   logic       overrun_clear;

   int n_vec = 0;
   int n_err = 0;
   int n_pop = 0;
   bit check_en = 1'b0;
   logic [7:0] seen[$];

   data_island_scheduler #(
      .INFOFRAME_MAX_DEFER (MAXD),
      .PACKET_CYCLES       (PC)
   ) dut (
      .clk_pixel              (clk_pixel),
      .reset_n                (reset_n),
      .frame_start            (frame_start),
      .packet_slot            (packet_slot),
      .clk_audio_counter_wrap (clk_audio_counter_wrap),
      .audio_sample_valid     (audio_sample_valid),
      .audio_sample_pop       (audio_sample_pop),
      .packet_type            (packet_type),
      .packet_start           (packet_start),
      .packet_active          (packet_active),
      .slot_overrun           (slot_overrun),
      .overrun_clear          (overrun_clear)
   );

   // Pixel clock.
   always #5 clk_pixel = ~clk_pixel;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- slot-level reference model ----------------
   bit         m_acr, m_avi, m_aif, m_spd;
   int         m_losses;
   int         m_busy;      // cycles of the current packet still to show
   logic [7:0] m_type;
   bit         m_overrun;
   logic       m_wrap_prev;
   bit         m_take;
   logic [7:0] m_pick;

   function automatic logic [7:0] pick_type();
      if (m_acr) return 8'h01;
      if (m_losses >= MAXD && (m_avi || m_aif || m_spd))
         return m_avi ? 8'h82 : (m_aif ? 8'h84 : 8'h83);
      if (audio_sample_valid) return 8'h02;
      if (m_avi) return 8'h82;
      if (m_aif) return 8'h84;
      if (m_spd) return 8'h83;
      return 8'h00;
   endfunction

   // Model update at each accepting edge; reset wipes it asynchronously.
   always @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         m_acr = 0; m_avi = 0; m_aif = 0; m_spd = 0;
         m_losses = 0; m_busy = 0; m_type = 8'h00;
         m_overrun = 0; m_wrap_prev = 1'b0;
      end else begin
         m_take = packet_slot && (m_busy == 0);
         if (m_busy == PC) begin
            if (m_type == 8'h01) m_acr = 0;
            if (m_type == 8'h82) m_avi = 0;
            if (m_type == 8'h84) m_aif = 0;
            if (m_type == 8'h83) m_spd = 0;
         end
         if (m_take) begin
            m_pick = pick_type();
            if (m_pick == 8'h02 && (m_avi || m_aif || m_spd))
               m_losses = (m_losses + 1 > MAXD) ? MAXD : m_losses + 1;
            else if (m_pick == 8'h82 || m_pick == 8'h84 || m_pick == 8'h83)
               m_losses = 0;
            m_type = m_pick;
         end
         if (overrun_clear) m_overrun = 0;
         if (packet_slot && m_busy != 0) m_overrun = 1;
         if (clk_audio_counter_wrap != m_wrap_prev) m_acr = 1;
         m_wrap_prev = clk_audio_counter_wrap;
         if (frame_start) begin
            m_avi = 1;
            m_aif = 1;
`ifdef SPD_INFOFRAME_EN
            m_spd = 1;
`endif
         end
         m_busy = m_take ? PC : ((m_busy > 0) ? m_busy - 1 : 0);
      end
   end

   // Every-cycle comparison against the model, plus grant/pop logging.
   always @(negedge clk_pixel) begin
      if (check_en) begin
         check("active",  8'(packet_active),    8'(m_busy > 0));
         check("start",   8'(packet_start),     8'(m_busy == PC));
         check("pop",     8'(audio_sample_pop), 8'(m_busy == PC && m_type == 8'h02));
         check("type",    packet_type,          m_type);
         check("overrun", 8'(slot_overrun),     8'(m_overrun));
         if (packet_start) seen.push_back(packet_type);
         if (audio_sample_pop) n_pop++;
      end
   end

   // Slot pulse; returns on the falling edge of the GRANT cycle.
   task automatic do_slot();
      @(negedge clk_pixel) packet_slot = 1'b1;
      @(negedge clk_pixel) packet_slot = 1'b0;
   endtask

   // Slot pulse followed by the whole packet and one idle cycle.
   task automatic run_slot();
      do_slot();
      repeat (PC + 1) @(negedge clk_pixel);
   endtask

   task automatic pulse_frame();
      @(negedge clk_pixel) frame_start = 1'b1;
      @(negedge clk_pixel) frame_start = 1'b0;
   endtask

   // Hang guard.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   logic [7:0] exp4[4];
   int n_act, n_st;

   initial begin
      reset_n = 1'b1;
      frame_start = 1'b0;
      packet_slot = 1'b0;
      clk_audio_counter_wrap = 1'b0;
      audio_sample_valid = 1'b0;
      overrun_clear = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      check("rst_type",    packet_type,          8'h00);
      check("rst_active",  8'(packet_active),    8'h00);
      check("rst_start",   8'(packet_start),     8'h00);
      check("rst_pop",     8'(audio_sample_pop), 8'h00);
      check("rst_overrun", 8'(slot_overrun),     8'h00);
      check_en = 1'b1;
      repeat (2) @(negedge clk_pixel);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_pixel);

      // ACR request then one slot: 0x01, one start, 32 active cycles.
      clk_audio_counter_wrap = ~clk_audio_counter_wrap;
      @(negedge clk_pixel);
      seen.delete();
      do_slot();
      check("acr_type",  packet_type,      8'h01);
      check("acr_start", 8'(packet_start), 8'h01);
      n_act = 0; n_st = 0;
      for (int i = 0; i < PC + 8; i++) begin
         if (packet_active) n_act++;
         if (packet_start)  n_st++;
         @(negedge clk_pixel);
      end
      check("acr_active_len", 8'(n_act), 8'd32);
      check("acr_start_cnt",  8'(n_st),  8'd1);

      // Frame start, four idle slots.
      seen.delete();
      pulse_frame();
      repeat (4) run_slot();
`ifdef SPD_INFOFRAME_EN
      exp4 = '{8'h82, 8'h84, 8'h83, 8'h00};
`else
      exp4 = '{8'h82, 8'h84, 8'h00, 8'h00};
`endif
      check("frame_slots", 8'(seen.size()), 8'd4);
      for (int i = 0; i < 4; i++)
         check($sformatf("frame_slot%0d", i), seen[i], exp4[i]);

      // Audio held valid: eight samples, promoted AVI, then audio again.
      audio_sample_valid = 1'b1;
      seen.delete();
      n_pop = 0;
      pulse_frame();
      repeat (10) run_slot();
      audio_sample_valid = 1'b0;
      check("audio_slots", 8'(seen.size()), 8'd10);
      for (int i = 0; i < 10; i++)
         check($sformatf("audio_slot%0d", i), seen[i], (i == 8) ? 8'h82 : 8'h02);
      check("audio_pops", 8'(n_pop), 8'd9);
      repeat (3) run_slot();

      // Slot arriving mid-packet is ignored and flags an overrun.
      seen.delete();
      do_slot();
      repeat (4) @(negedge clk_pixel);
      packet_slot = 1'b1;
      @(negedge clk_pixel) packet_slot = 1'b0;
      check("ovr_set",    8'(slot_overrun),  8'h01);
      check("ovr_active", 8'(packet_active), 8'h01);
      repeat (5) @(negedge clk_pixel);
      check("ovr_sticky", 8'(slot_overrun), 8'h01);
      packet_slot = 1'b1;
      overrun_clear = 1'b1;
      @(negedge clk_pixel);
      packet_slot = 1'b0;
      overrun_clear = 1'b0;
      check("ovr_set_wins", 8'(slot_overrun), 8'h01);
      overrun_clear = 1'b1;
      @(negedge clk_pixel) overrun_clear = 1'b0;
      check("ovr_cleared", 8'(slot_overrun), 8'h00);
      repeat (PC) @(negedge clk_pixel);
      check("ovr_no_extra", 8'(seen.size()), 8'd1);
      check("ovr_idle",     8'(packet_active), 8'h00);

      // New ACR request during the ACR GRANT cycle survives the clear.
      seen.delete();
      clk_audio_counter_wrap = ~clk_audio_counter_wrap;
      @(negedge clk_pixel);
      do_slot();
      clk_audio_counter_wrap = ~clk_audio_counter_wrap;
      check("acr2_type", packet_type, 8'h01);
      repeat (PC + 1) @(negedge clk_pixel);
      run_slot();
      run_slot();
      check("acr2_slots", 8'(seen.size()), 8'd3);
      check("acr2_again", seen[1], 8'h01);
      check("acr2_drain", seen[2], 8'h00);

      // Reset in the middle of HOLD aborts the packet.
      pulse_frame();
      seen.delete();
      do_slot();
      repeat (10) @(negedge clk_pixel);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_type",   packet_type,          8'h00);
      check("mid_rst_active", 8'(packet_active),    8'h00);
      check("mid_rst_start",  8'(packet_start),     8'h00);
      check("mid_rst_pop",    8'(audio_sample_pop), 8'h00);
      clk_audio_counter_wrap = 1'b0;
      repeat (2) @(negedge clk_pixel);
      reset_n = 1'b1;
      seen.delete();
      run_slot();
      check("post_rst_slots", 8'(seen.size()), 8'd1);
      check("post_rst_type",  seen[0],         8'h00);

      repeat (2) @(negedge clk_pixel);
      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
